// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-access stage and its lane aligner.
package mem_access_pkg;

    typedef logic [63:0] u64;
    typedef logic [7:0]  u8;
    typedef logic [4:0]  u5;

    // Encoding 3 is reserved and behaves like OP_NONE.
    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2,
        OP_RSVD  = 2'd3
    } mem_op_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // Byte-lane enable pattern for an aligned access of each size, packed B..D low to high.
    localparam logic [31:0] STROBE_BASE_TABLE = {8'hFF, 8'h0F, 8'h03, 8'h01};

    function automatic u8 strobe_base(input mem_size_t size);
        return STROBE_BASE_TABLE[{size, 3'b000} +: 8];
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] size_mask(input mem_size_t size);
        case (size)
            SZ_B:    return 3'b000;
            SZ_H:    return 3'b001;
            SZ_W:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_align.sv
// mem_align: combinational byte-lane logic for a 64-bit data bus.
// Produces the store strobe and shifted store data, and extracts/extends load data.
module mem_align
    import mem_access_pkg::*;
(
    input  logic [2:0] off,
    input  mem_size_t  size,
    input  logic       is_unsigned,
    input  u64         store_data,
    input  u64         load_raw,
    output u8          strobe,
    output u64         store_lanes,
    output u64         load_value
);

    logic [5:0] bit_shift;
    u64         shifted;
    u8          keep;
    logic       sign_bit;
    u8          fill_byte;

    assign bit_shift   = {off, 3'b000};
    // Lanes pushed past byte 7 fall off the top; misaligned accesses lose them.
    assign strobe      = strobe_base(size) << off;
    assign store_lanes = store_data << bit_shift;
    assign shifted     = load_raw >> bit_shift;
    // The aligned strobe pattern doubles as the "bytes kept" mask after the shift.
    assign keep        = strobe_base(size);

    // Pick the sign bit of the loaded element.
    always_comb begin
        sign_bit = shifted[63];
        case (size)
            SZ_B:    sign_bit = shifted[7];
            SZ_H:    sign_bit = shifted[15];
            SZ_W:    sign_bit = shifted[31];
            default: sign_bit = shifted[63];
        endcase
    end

    assign fill_byte = is_unsigned ? 8'h00 : {8{sign_bit}};

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign load_value[8*gi +: 8] = keep[gi] ? shifted[8*gi +: 8] : fill_byte;
        end
    endgenerate

endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage after the execute ALU. Holds one instruction,
// runs a valid/ready bus transaction for loads/stores, and presents a
// registered writeback bundle. Optional macro MEM_MISALIGN_TRAP_EN adds
// out_misalign and turns misaligned accesses into a bus-less trap bundle.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] store_data,
    input  logic [1:0]        mem_op,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [4:0]        rd,
    input  logic              reg_write,
    output logic              dreq_valid,
    input  logic              dreq_ready,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic              dreq_write,
    output logic [7:0]        dreq_strobe,
    output logic [DATA_W-1:0] dreq_data,
    input  logic              dresp_valid,
    input  logic [DATA_W-1:0] dresp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [4:0]        out_rd,
    output logic              out_reg_write
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic              out_misalign
`endif
);

    state_t    state_reg, state_next;
    mem_op_t   op_in, op_reg;
    mem_size_t size_in, size_reg;
    logic      uns_reg;
    logic [2:0] off_reg;
    u5         rd_reg;
    logic      reg_write_reg;

    logic [ADDR_W-1:0] dreq_addr_reg;
    logic              dreq_write_reg;
    u8                 dreq_strobe_reg;
    logic [DATA_W-1:0] dreq_data_reg;
    logic [DATA_W-1:0] out_data_reg;
    u5                 out_rd_reg;
    logic              out_reg_write_reg;

    logic       accept;
    logic       is_mem_in;
    logic       trap_in;
    logic       goes_to_bus;
    logic       resp_take;
    logic [2:0] align_off;
    mem_size_t  align_size;
    u8          align_strobe;
    u64         align_store;
    u64         align_load;

    assign op_in     = mem_op_t'(mem_op);
    assign size_in   = mem_size_t'(mem_size);
    assign is_mem_in = (op_in == OP_LOAD) || (op_in == OP_STORE);

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_reg;
    assign trap_in = is_mem_in && ((alu_out[2:0] & size_mask(size_in)) != 3'b000);
`else
    assign trap_in = 1'b0;
`endif

    assign goes_to_bus = is_mem_in && !trap_in;

    // Held in reset the stage accepts nothing, even though the state reads IDLE.
    assign in_ready  = rst_n && ((state_reg == ST_IDLE) || ((state_reg == ST_OUT) && out_ready));
    assign accept    = in_valid && in_ready;
    assign resp_take = (state_reg == ST_WAIT) && dresp_valid;

    assign dreq_valid    = (state_reg == ST_REQ);
    assign out_valid     = (state_reg == ST_OUT);
    assign dreq_addr     = dreq_addr_reg;
    assign dreq_write    = dreq_write_reg;
    assign dreq_strobe   = dreq_strobe_reg;
    assign dreq_data     = dreq_data_reg;
    assign out_data      = out_data_reg;
    assign out_rd        = out_rd_reg;
    assign out_reg_write = out_reg_write_reg;

    // The aligner serves the incoming store on accept and the captured load in WAIT.
    assign align_off  = (state_reg == ST_WAIT) ? off_reg  : alu_out[2:0];
    assign align_size = (state_reg == ST_WAIT) ? size_reg : size_in;

    mem_align u_align (
        .off         (align_off),
        .size        (align_size),
        .is_unsigned (uns_reg),
        .store_data  (store_data),
        .load_raw    (dresp_data),
        .strobe      (align_strobe),
        .store_lanes (align_store),
        .load_value  (align_load)
    );

    // State register; asynchronous reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = goes_to_bus ? ST_REQ : ST_OUT;
            ST_REQ:  if (dreq_ready) state_next = ST_WAIT;
            ST_WAIT: if (dresp_valid) state_next = ST_OUT;
            ST_OUT: begin
                if (out_ready) begin
                    if (accept) state_next = goes_to_bus ? ST_REQ : ST_OUT;
                    else        state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Instruction capture, bus request fields and writeback bundle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg            <= OP_NONE;
            size_reg          <= SZ_B;
            uns_reg           <= 1'b0;
            off_reg           <= 3'b000;
            rd_reg            <= '0;
            reg_write_reg     <= 1'b0;
            dreq_addr_reg     <= '0;
            dreq_write_reg    <= 1'b0;
            dreq_strobe_reg   <= '0;
            dreq_data_reg     <= '0;
            out_data_reg      <= '0;
            out_rd_reg        <= '0;
            out_reg_write_reg <= 1'b0;
        end else begin
            if (accept) begin
                op_reg        <= op_in;
                size_reg      <= size_in;
                uns_reg       <= mem_unsigned;
                off_reg       <= alu_out[2:0];
                rd_reg        <= rd;
                reg_write_reg <= reg_write;
                if (goes_to_bus) begin
                    dreq_addr_reg   <= alu_out;
                    dreq_write_reg  <= (op_in == OP_STORE);
                    dreq_strobe_reg <= align_strobe;
                    dreq_data_reg   <= align_store;
                end else begin
                    // Pass-through result, or the faulting address for a trapped access.
                    out_data_reg      <= alu_out;
                    out_rd_reg        <= rd;
                    out_reg_write_reg <= reg_write && !trap_in;
                end
            end
            if (resp_take) begin
                out_data_reg      <= (op_reg == OP_STORE) ? '0 : align_load;
                out_rd_reg        <= rd_reg;
                out_reg_write_reg <= (op_reg == OP_STORE) ? 1'b0 : reg_write_reg;
            end
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // Misalignment flag travels with the bundle; bus completions always clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         misalign_reg <= 1'b0;
        else if (accept)    misalign_reg <= trap_in;
        else if (resp_take) misalign_reg <= 1'b0;
    end
    assign out_misalign = misalign_reg;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: scoreboard of expected writeback bundles,
// procedural bus responder, reset/back-pressure/throughput corner cases.
// Optional macro MEM_MISALIGN_TRAP_EN enables the misalignment trap checks.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [63:0] alu_out, store_data;
    logic [1:0]  mem_op, mem_size;
    logic        mem_unsigned;
    logic [4:0]  rd;
    logic        reg_write;
    logic        dreq_valid, dreq_ready, dreq_write;
    logic [63:0] dreq_addr, dreq_data;
    logic [7:0]  dreq_strobe;
    logic        dresp_valid;
    logic [63:0] dresp_data;
    logic        out_valid, out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic        out_reg_write;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        out_misalign;
`endif

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_out       (alu_out),
        .store_data    (store_data),
        .mem_op        (mem_op),
        .mem_size      (mem_size),
        .mem_unsigned  (mem_unsigned),
        .rd            (rd),
        .reg_write     (reg_write),
        .dreq_valid    (dreq_valid),
        .dreq_ready    (dreq_ready),
        .dreq_addr     (dreq_addr),
        .dreq_write    (dreq_write),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_valid   (dresp_valid),
        .dresp_data    (dresp_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .out_misalign  (out_misalign)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_trap(input logic [1:0] op, input logic [1:0] size, input logic [63:0] addr);
`ifdef MEM_MISALIGN_TRAP_EN
        int nb;
        nb = 1 << size;
        return (op == 2'd1 || op == 2'd2) && ((int'(addr[2:0]) % nb) != 0);
`else
        return 1'b0;
`endif
    endfunction

    // Reference model of the writeback bundle, built byte by byte.
    function automatic exp_t model(input logic [1:0] op, input logic [1:0] size, input logic uns,
                                   input logic [63:0] addr, input logic [63:0] resp,
                                   input logic [4:0] r, input logic rw);
        exp_t        e;
        int          nb, off;
        logic [63:0] v;
        logic        sb;
        e.rd = r;
        nb   = 1 << size;
        off  = int'(addr[2:0]);
        if (is_trap(op, size, addr)) begin
            e.data = addr;
            e.rw   = 1'b0;
        end else if (op == 2'd2) begin
            e.data = 64'h0;
            e.rw   = 1'b0;
        end else if (op == 2'd1) begin
            v = 64'h0;
            for (int i = 0; i < nb; i++)
                if (off + i < 8) v[8*i +: 8] = resp[8*(off+i) +: 8];
            if (!uns && nb < 8) begin
                sb = v[8*nb-1];
                for (int j = nb; j < 8; j++) v[8*j +: 8] = {8{sb}};
            end
            e.data = v;
            e.rw   = rw;
        end else begin
            e.data = addr;
            e.rw   = rw;
        end
        return e;
    endfunction

    task automatic drive_in(input logic [1:0] op, input logic [1:0] size, input logic uns,
                            input logic [63:0] addr, input logic [63:0] sdata,
                            input logic [4:0] r, input logic rw);
        int n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        check("in_ready_wait", {63'h0, in_ready}, 64'h1);
        mem_op = op; mem_size = size; mem_unsigned = uns;
        alu_out = addr; store_data = sdata; rd = r; reg_write = rw;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_dreq();
        int n = 0;
        while (!dreq_valid && n < 50) begin @(negedge clk); n++; end
        check("dreq_wait", {63'h0, dreq_valid}, 64'h1);
    endtask

    task automatic serve_bus(input logic [63:0] addr, input logic wr, input logic [7:0] stb,
                             input logic [63:0] data, input logic [63:0] resp, input int delay);
        wait_dreq();
        for (int c = 0; c <= delay; c++) begin
            check("req_addr", dreq_addr, addr);
            check("req_write", {63'h0, dreq_write}, {63'h0, wr});
            check("req_strobe", {56'h0, dreq_strobe}, {56'h0, stb});
            check("req_data", dreq_data, data);
            check("req_in_ready", {63'h0, in_ready}, 64'h0);
            if (c < delay) begin
                check("req_valid_hold", {63'h0, dreq_valid}, 64'h1);
                @(negedge clk);
            end
        end
        // A response coincident with the request handshake must be ignored.
        dreq_ready = 1'b1; dresp_valid = 1'b1; dresp_data = ~resp;
        @(negedge clk);
        dreq_ready = 1'b0; dresp_valid = 1'b0;
        check("wait_no_req", {63'h0, dreq_valid}, 64'h0);
        check("wait_no_out", {63'h0, out_valid}, 64'h0);
        @(negedge clk);
        check("wait_ignore_early", {63'h0, out_valid}, 64'h0);
        dresp_valid = 1'b1; dresp_data = resp;
        @(negedge clk);
        dresp_valid = 1'b0;
    endtask

    task automatic collect(input int stall);
        int   n = 0;
        exp_t e;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        check("out_wait", {63'h0, out_valid}, 64'h1);
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'h1, 64'h0);
            return;
        end
        e = sb_q.pop_front();
        for (int c = 0; c < stall; c++) begin
            check("stall_data", out_data, e.data);
            check("stall_in_ready", {63'h0, in_ready}, 64'h0);
            @(negedge clk);
            check("stall_valid", {63'h0, out_valid}, 64'h1);
        end
        check("out_data", out_data, e.data);
        check("out_rd", {59'h0, out_rd}, {59'h0, e.rd});
        check("out_reg_write", {63'h0, out_reg_write}, {63'h0, e.rw});
        $display("txn rd=%0d data=%h rw=%0d", out_rd, out_data, out_reg_write);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [1:0] size, input logic uns,
                          input logic [63:0] addr, input logic [63:0] sdata, input logic [63:0] resp,
                          input logic [4:0] r, input logic rw, input int delay, input int stall);
        logic [15:0] stb_wide;
        logic [7:0]  base;
        logic [63:0] lanes;
        logic        trap;
        trap = is_trap(op, size, addr);
        sb_q.push_back(model(op, size, uns, addr, resp, r, rw));
        drive_in(op, size, uns, addr, sdata, r, rw);
        if ((op == 2'd1 || op == 2'd2) && !trap) begin
            case (size)
                2'd0: base = 8'h01;
                2'd1: base = 8'h03;
                2'd2: base = 8'h0F;
                default: base = 8'hFF;
            endcase
            stb_wide = {8'h00, base} << addr[2:0];
            lanes    = sdata << (8 * addr[2:0]);
            serve_bus(addr, op == 2'd2, stb_wide[7:0], lanes, resp, delay);
        end else begin
            check("lat1_valid", {63'h0, out_valid}, 64'h1);
            check("lat1_no_req", {63'h0, dreq_valid}, 64'h0);
        end
`ifdef MEM_MISALIGN_TRAP_EN
        if (out_valid) check("misalign", {63'h0, out_misalign}, {63'h0, trap});
`endif
        collect(stall);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst_n = 1'b0; in_valid = 1'b0; alu_out = '0; store_data = '0; mem_op = '0;
        mem_size = '0; mem_unsigned = 1'b0; rd = '0; reg_write = 1'b0;
        dreq_ready = 1'b0; dresp_valid = 1'b0; dresp_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {63'h0, in_ready}, 64'h0);
        check("rst_dreq_valid", {63'h0, dreq_valid}, 64'h0);
        check("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("rst_out_data", out_data, 64'h0);
        check("rst_dreq_strobe", {56'h0, dreq_strobe}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(2'd0, 2'd3, 1'b0, 64'h1234, 64'h0, 64'h0, 5'd5, 1'b1, 0, 0);
        run_op(2'd2, 2'd2, 1'b0, 64'h1004, 64'hDEADBEEF, 64'h0, 5'd7, 1'b1, 0, 0);
        run_op(2'd1, 2'd0, 1'b0, 64'h2003, 64'h0, 64'h00000000_80000000, 5'd8, 1'b1, 0, 0);
        run_op(2'd1, 2'd0, 1'b1, 64'h2003, 64'h0, 64'h00000000_80000000, 5'd9, 1'b1, 0, 0);
        run_op(2'd2, 2'd3, 1'b0, 64'h4000, 64'h01234567_89ABCDEF, 64'h0, 5'd3, 1'b1, 3, 2);
        run_op(2'd1, 2'd1, 1'b0, 64'h2006, 64'h0, 64'h9ABC0000_00000000, 5'd4, 1'b1, 1, 0);
        run_op(2'd1, 2'd2, 1'b1, 64'h2004, 64'h0, 64'hF00DCAFE_00000000, 5'd6, 1'b0, 0, 1);
        run_op(2'd1, 2'd3, 1'b1, 64'h2008, 64'h0, 64'h80000000_00000001, 5'd11, 1'b1, 0, 0);
        run_op(2'd3, 2'd0, 1'b0, 64'h5555, 64'h0, 64'h0, 5'd12, 1'b1, 0, 0);
        run_op(2'd2, 2'd1, 1'b0, 64'h7002, 64'h0000_0000_0000_BEEF, 64'h0, 5'd13, 1'b1, 0, 0);

        for (int k = 0; k < 6; k++)
            run_op(2'd1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   64'h6000 + 64'($urandom_range(0, 7)), 64'h0, {$urandom, $urandom},
                   5'(k + 16), 1'b1, k % 2, k % 3);

        // Back-to-back NONE ops: one result per cycle with out_ready held high.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(model(2'd0, 2'd0, 1'b0, 64'h100 + 64'(i), 64'h0, 5'(i + 1), 1'b1));
            mem_op = 2'd0; alu_out = 64'h100 + 64'(i); rd = 5'(i + 1); reg_write = 1'b1;
            in_valid = 1'b1;
            @(negedge clk);
            e = sb_q.pop_front();
            check("tput_valid", {63'h0, out_valid}, 64'h1);
            check("tput_data", out_data, e.data);
            check("tput_rd", {59'h0, out_rd}, {59'h0, e.rd});
            $display("txn rd=%0d data=%h rw=%0d", out_rd, out_data, out_reg_write);
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check("tput_idle", {63'h0, out_valid}, 64'h0);

        // Reset while waiting for a load response.
        drive_in(2'd1, 2'd2, 1'b0, 64'h5000, 64'h0, 5'd2, 1'b1);
        wait_dreq();
        dreq_ready = 1'b1;
        @(negedge clk);
        dreq_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_dreq_valid", {63'h0, dreq_valid}, 64'h0);
        check("arst_out_valid", {63'h0, out_valid}, 64'h0);
        check("arst_in_ready", {63'h0, in_ready}, 64'h0);
        check("arst_out_data", out_data, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dresp_valid = 1'b1; dresp_data = 64'h1111_2222_3333_4444;
        @(negedge clk);
        dresp_valid = 1'b0;
        check("arst_resp_ignored", {63'h0, out_valid}, 64'h0);
        check("arst_no_req", {63'h0, dreq_valid}, 64'h0);
        @(negedge clk);
        check("arst_still_idle", {63'h0, out_valid}, 64'h0);
        $display("txn reset-abort load addr=%h", 64'h5000);

        run_op(2'd0, 2'd0, 1'b0, 64'hABCD, 64'h0, 64'h0, 5'd1, 1'b1, 0, 0);
`ifdef MEM_MISALIGN_TRAP_EN
        run_op(2'd1, 2'd1, 1'b0, 64'h3001, 64'h0, 64'h0, 5'd10, 1'b1, 0, 0);
        run_op(2'd2, 2'd2, 1'b0, 64'h3006, 64'h55, 64'h0, 5'd10, 1'b1, 0, 0);
`endif
        check("sb_drained", 64'(sb_q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage directly downstream of the execute ALU.
- Takes the 64-bit ALU result as an effective address (loads/stores) or as a pass-through result (all other ops).
- Runs a valid/ready data-bus transaction, aligns and extends load data, and presents a registered writeback bundle to the next stage.
- Holds one instruction at a time and back-pressures execute while busy.

Parameters:
- ADDR_W, 64, width of the address and of alu_out
- DATA_W, 64, data-bus width (8 byte lanes); only 64 is supported

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  execute result valid
- in_ready  out  1  stage can accept
- alu_out  in  64  ALU result / effective address
- store_data  in  64  rs2 value for stores
- mem_op  in  2  mem_op_t: NONE=0, LOAD=1, STORE=2 (3 treated as NONE)
- mem_size  in  2  mem_size_t: B=0, H=1, W=2, D=3
- mem_unsigned  in  1  zero-extend load when 1
- rd  in  5  destination register
- reg_write  in  1  writeback enable
- dreq_valid  out  1  bus request valid
- dreq_ready  in  1  bus accepts request
- dreq_addr  out  64  request address
- dreq_write  out  1  1 = store
- dreq_strobe  out  8  byte-lane enables
- dreq_data  out  64  lane-aligned store data
- dresp_valid  in  1  bus response / store ack
- dresp_data  in  64  raw load data
- out_valid  out  1  writeback bundle valid
- out_ready  in  1  next stage accepts
- out_data  out  64  result to write back
- out_rd  out  5  destination register
- out_reg_write  out  1  writeback enable (forced 0 for stores)

Behaviour:
- Reset: state=IDLE. All outputs 0: dreq_valid, out_valid, out_data, out_rd, out_reg_write, dreq_addr, dreq_strobe, dreq_data, dreq_write. in_ready=0 while rst_n=0.
- Reset mid-transaction:
  - Asynchronous abort; dreq_valid drops immediately.
  - Captured instruction is discarded.
  - A later dresp_valid is ignored because the state is IDLE.
- FSM states: IDLE, REQ, WAIT, OUT.
  - IDLE: in_ready=1. Accept on in_valid&&in_ready, capturing all inputs.
  - NONE op: next state OUT with out_data=alu_out. Latency is 1 cycle.
  - LOAD/STORE op: next state REQ.
  - REQ: dreq_valid=1 with stable addr, strobe, data and write until dreq_ready; then go to WAIT.
  - WAIT: sample dresp_valid only here. A dresp_valid in the same cycle as the REQ handshake is ignored; the bus guarantees at least 1 cycle of latency. On dresp_valid: compute the load result (stores: out_data=0) and go to OUT.
  - OUT: out_valid=1, bundle stable until out_ready. On out_ready:
    - if in_valid, accept the next instruction in the same cycle (in_ready=1 in OUT when out_ready=1);
    - otherwise go to IDLE.
- Best-case throughput:
  - NONE ops: 1 instruction/cycle.
  - Memory ops: REQ(1) + WAIT(>=1) + OUT(1).
- Lane arithmetic (off = addr[2:0]):
  - dreq_addr = alu_out (full address, not aligned down).
  - strobe = ({01,03,0F,FF}[size] << off), truncated to 8 bits.
  - dreq_data = store_data << (8*off), truncated to 64 bits.
  - Load: raw = dresp_data >> (8*off). Take the low 8/16/32/64 bits, then sign-extend (or zero-extend if mem_unsigned). D ignores mem_unsigned.
- Stores: out_reg_write=0 regardless of the reg_write input.
- out_rd and out_reg_write are passed through unchanged for all other ops.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port out_misalign (1 bit, reset 0).
  - An access with (addr & (size_bytes-1))!=0 issues no bus request and goes IDLE→OUT directly.
  - In that OUT: out_misalign=1, out_reg_write=0, out_data=alu_out (faulting address).
- Undefined:
  - No port.
  - Misaligned accesses are issued as-is, with the truncated strobe and shift above. Data in lanes beyond byte 7 is lost.

Decomposition:
- Shared package common: typedefs mem_op_t, mem_size_t (2-bit enums), u64/u8/u5, and a constant table mapping size to strobe base.
- Sub-module mem_align: purely combinational; computes strobe, store shift, and load extract/extend. Reused by a future cache.

Test Plan:
- NONE op, alu_out=0x1234, rd=5, reg_write=1, out_ready=1 → next cycle out_valid=1, out_data=0x1234, out_rd=5; no dreq_valid.
- STORE W at addr 0x1004, store_data=0xDEADBEEF → dreq_addr=0x1004, strobe=0xF0, dreq_data=0xDEADBEEF_00000000, dreq_write=1; after ack out_reg_write=0.
- LOAD B signed at addr 0x2003, dresp_data=0x00000000_80000000 → out_data=0xFFFFFFFF_FFFFFF80. Same with mem_unsigned=1 → 0x80.
- Back-pressure: dreq_ready low 3 cycles, then out_ready low 2 cycles → request fields stable throughout; in_ready=0 until the OUT handshake.
- rst_n pulsed low while in WAIT, then dresp_valid arrives → dreq_valid=0 and out_valid=0 immediately; the response is ignored.
- With MEM_MISALIGN_TRAP_EN: LOAD H at 0x3001 → no dreq_valid, out_misalign=1, out_data=0x3001.
